// File: rtl/tcp_bench_pkg.sv
// tcp_bench_pkg: shared constants, field offsets and FSM states for the TCP benchmark engines.
package tcp_bench_pkg;
  localparam int WORD_BYTES = 64;
  localparam int META_W = 48;
  localparam int SESS_LSB = 0;
  localparam int SESS_W = 16;
  localparam int LEN_LSB = 16;
  localparam int LEN_W = 32;
  localparam int CTRL_LEN = 1;
  localparam int CTRL_OPS = 2;
  localparam int CTRL_OFFSET = 3;
  localparam int CTRL_START = 7;
  localparam int START_BIT = 1;
  localparam int ST_CYCLES = 0;
  localparam int ST_NOTIFS = 1;
  localparam int ST_WORDS = 2;
  localparam int ST_ERRORS = 3;
  localparam int ST_FIRST_ERR = 4;
  localparam int ST_OPS_DONE = 5;
  localparam int ST_STATE = 6;
  localparam int ST_ZERO = 7;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_NOTIF = 2'd1, ISSUE_REQ = 2'd2} state_e;
endpackage

// File: rtl/tcp_rx_pattern_checker.sv
// tcp_rx_pattern_checker: compares each rx beat with word_idx + offset and tracks errors and completed transfers.
module tcp_rx_pattern_checker #(
  parameter int WORD_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_clear,
  input  logic                    i_beat,
  input  logic [WORD_BYTES*8-1:0] i_data,
  input  logic [WORD_BYTES-1:0]   i_keep,
  input  logic [31:0]             i_offset,
  input  logic [31:0]             i_len,
  input  logic [31:0]             i_words,
  output logic [31:0]             o_errors,
  output logic [31:0]             o_first_err,
  output logic [31:0]             o_ops_done
);
  localparam int SH = $clog2(WORD_BYTES);
  logic [31:0] r_word_idx, r_errors, r_first_err, r_ops_done;
  logic r_seen;
  logic [WORD_BYTES*8-1:0] w_exp;
  logic [31:0] w_last_idx;
  logic w_mis, w_wrap;
  assign w_exp = {{(WORD_BYTES*8-32){1'b0}}, r_word_idx + i_offset};
  assign w_last_idx = (i_len >> SH) - 32'd1;
  assign w_wrap = r_word_idx == w_last_idx;
  // only bytes flagged by keep take part in the compare
  always_comb begin
    w_mis = 1'b0;
    for (int b = 0; b < WORD_BYTES; b++)
      w_mis = w_mis | (i_keep[b] & (i_data[b*8 +: 8] != w_exp[b*8 +: 8]));
  end
  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_word_idx  <= '0;
      r_errors    <= '0;
      r_first_err <= '1;
      r_seen      <= 1'b0;
      r_ops_done  <= '0;
    end else if (i_beat) begin
      r_word_idx <= w_wrap ? 32'd0 : r_word_idx + 32'd1;
      r_ops_done <= r_ops_done + {31'd0, w_wrap};
      if (w_mis) begin
        r_errors <= r_errors + 32'd1;
        if (!r_seen) begin
          r_first_err <= i_words;
          r_seen      <= 1'b1;
        end
      end
    end
  end
  assign o_errors    = r_errors;
  assign o_first_err = r_first_err;
  assign o_ops_done  = r_ops_done;
endmodule

// File: rtl/tcp_recv_check_engine.sv
// tcp_recv_check_engine: accepts TOE notifications, issues read-package requests and checks rx data
// against the send engine's pattern, reporting counters through status registers.
module tcp_recv_check_engine #(
  parameter int WORD_BYTES = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_notif_valid,
  output logic                    o_notif_ready,
  input  logic [47:0]             i_notif_data,
  output logic                    o_read_valid,
  input  logic                    i_read_ready,
  output logic [47:0]             o_read_data,
  input  logic                    i_rx_meta_valid,
  output logic                    o_rx_meta_ready,
  input  logic [15:0]             i_rx_meta_data,
  input  logic                    i_rx_data_valid,
  output logic                    o_rx_data_ready,
  input  logic [WORD_BYTES*8-1:0] i_rx_data_data,
  input  logic [WORD_BYTES-1:0]   i_rx_data_keep,
  input  logic                    i_rx_data_last,
  input  logic [15:0][31:0]       i_control_reg,
  output logic [7:0][31:0]        o_status_reg
);
  import tcp_bench_pkg::*;
  logic [31:0] r_len, r_ops, r_offset;
  logic r_start, r_start_rr, r_armed;
  state_e r_state;
  logic [47:0] r_req_data;
  logic [31:0] r_cycles, r_notifs, r_words;
  logic [7:0][31:0] r_status;
  logic [31:0] w_errors, w_first_err, w_ops_done;
  logic w_start, w_notif_hs, w_read_hs, w_done, w_unused;
  assign w_start         = r_start & ~r_start_rr;
  assign o_notif_ready   = (r_state == WAIT_NOTIF) & ~w_start;
  assign w_notif_hs      = i_notif_valid & o_notif_ready;
  assign o_read_valid    = r_state == ISSUE_REQ;
  assign o_read_data     = r_req_data;
  assign w_read_hs       = o_read_valid & i_read_ready;
  assign w_done          = (r_ops != 32'd0) & (w_ops_done == r_ops);
  assign o_rx_meta_ready = 1'b1;
  assign o_rx_data_ready = 1'b1;
  assign o_status_reg    = r_status;
  assign w_unused = ^{i_rx_meta_valid, i_rx_meta_data, i_rx_data_last, i_control_reg[0], i_control_reg[6:4],
                      i_control_reg[7][31:2], i_control_reg[7][0], i_control_reg[15:8]};
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_len      <= '0;
      r_ops      <= '0;
      r_offset   <= '0;
      r_start    <= 1'b0;
      r_start_rr <= 1'b0;
    end else begin
      r_len      <= i_control_reg[CTRL_LEN];
      r_ops      <= i_control_reg[CTRL_OPS];
      r_offset   <= i_control_reg[CTRL_OFFSET];
      r_start    <= i_control_reg[CTRL_START][START_BIT];
      r_start_rr <= r_start;
    end
  end
  // a start edge overrides any pending request
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_req_data <= '0;
    end else if (w_start) begin
      r_state <= WAIT_NOTIF;
    end else if (w_notif_hs) begin
      r_req_data <= i_notif_data;
      r_state    <= (i_notif_data[LEN_LSB +: LEN_W] != 32'd0) ? ISSUE_REQ : WAIT_NOTIF;
    end else if (w_read_hs) begin
      r_state <= w_done ? IDLE : WAIT_NOTIF;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_armed  <= 1'b0;
      r_cycles <= '0;
      r_notifs <= '0;
      r_words  <= '0;
    end else if (w_start) begin
      r_armed  <= 1'b1;
      r_cycles <= '0;
      r_notifs <= '0;
      r_words  <= '0;
    end else begin
      r_cycles <= r_cycles + {31'd0, r_armed & ~w_done};
      r_notifs <= r_notifs + {31'd0, w_notif_hs};
      r_words  <= r_words + {31'd0, i_rx_data_valid};
    end
  end
  tcp_rx_pattern_checker #(.WORD_BYTES(WORD_BYTES)) u_checker (
    .clk        (clk),
    .rstn       (rstn),
    .i_clear    (w_start),
    .i_beat     (i_rx_data_valid),
    .i_data     (i_rx_data_data),
    .i_keep     (i_rx_data_keep),
    .i_offset   (r_offset),
    .i_len      (r_len),
    .i_words    (r_words),
    .o_errors   (w_errors),
    .o_first_err(w_first_err),
    .o_ops_done (w_ops_done)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_status               <= '0;
      r_status[ST_FIRST_ERR] <= '1;
    end else begin
      r_status[ST_CYCLES]    <= r_cycles;
      r_status[ST_NOTIFS]    <= r_notifs;
      r_status[ST_WORDS]     <= r_words;
      r_status[ST_ERRORS]    <= w_errors;
      r_status[ST_FIRST_ERR] <= w_first_err;
      r_status[ST_OPS_DONE]  <= w_ops_done;
      r_status[ST_STATE]     <= {30'd0, r_state};
      r_status[ST_ZERO]      <= '0;
    end
  end
endmodule

// File: tb/tb_tcp_recv_check_engine.sv
// tb_tcp_recv_check_engine: randomized scoreboard bench for the receive check engine.
module tb_tcp_recv_check_engine;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic i_notif_valid = 1'b0, o_notif_ready;
  logic [47:0] i_notif_data = '0;
  logic o_read_valid, i_read_ready = 1'b0;
  logic [47:0] o_read_data;
  logic i_rx_meta_valid = 1'b0, o_rx_meta_ready;
  logic [15:0] i_rx_meta_data = '0;
  logic i_rx_data_valid = 1'b0, o_rx_data_ready;
  logic [511:0] i_rx_data_data = '0;
  logic [63:0] i_rx_data_keep = '0;
  logic i_rx_data_last = 1'b0;
  logic [15:0][31:0] i_control_reg = '0;
  logic [7:0][31:0] o_status_reg;

  always #5 clk = ~clk;

  tcp_recv_check_engine #(.WORD_BYTES(64)) dut (
    .clk(clk), .rstn(rstn),
    .i_notif_valid(i_notif_valid), .o_notif_ready(o_notif_ready), .i_notif_data(i_notif_data),
    .o_read_valid(o_read_valid), .i_read_ready(i_read_ready), .o_read_data(o_read_data),
    .i_rx_meta_valid(i_rx_meta_valid), .o_rx_meta_ready(o_rx_meta_ready), .i_rx_meta_data(i_rx_meta_data),
    .i_rx_data_valid(i_rx_data_valid), .o_rx_data_ready(o_rx_data_ready), .i_rx_data_data(i_rx_data_data),
    .i_rx_data_keep(i_rx_data_keep), .i_rx_data_last(i_rx_data_last),
    .i_control_reg(i_control_reg), .o_status_reg(o_status_reg)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model of one measurement run
  int unsigned m_wpt = 1, m_ops = 0, m_beats = 0, m_errors = 0, m_notifs = 0;
  logic [31:0] m_off = '0, m_first = '1;
  int m_e = 0, m_l = 0;
  logic [47:0] exp_q[$];
  int acc_cyc = 0;
  bit mon_en = 1'b1;
  bit p_valid = 1'b0, p_pend = 1'b0;
  logic [47:0] p_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // read-request monitor: latency, stability under backpressure, content
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_read_valid && !p_valid) chk("req_latency", 64'(cyc), 64'(acc_cyc));
      if (p_pend) chk("req_stable", {15'd0, o_read_valid, o_read_data}, {15'd0, 1'b1, p_data});
      if (o_read_valid && i_read_ready) begin
        if (exp_q.size() == 0) chk("req_unexpected", 64'(o_read_data), 64'd0);
        else chk("req_data", 64'(o_read_data), 64'(exp_q.pop_front()));
      end
      p_valid = o_read_valid;
      p_pend  = o_read_valid && !i_read_ready;
      p_data  = o_read_data;
    end
  end

  task automatic cfg(input int unsigned len, input int unsigned ops, input logic [31:0] off);
    i_control_reg[1] = len;
    i_control_reg[2] = ops;
    i_control_reg[3] = off;
    m_wpt = len / 64;
    m_ops = ops;
    m_off = off;
  endtask

  task automatic model_clear();
    m_beats = 0;
    m_errors = 0;
    m_first = '1;
    m_notifs = 0;
  endtask

  task automatic do_start();
    i_control_reg[7][1] = 1'b0;
    tick(3);
    i_control_reg[7][1] = 1'b1;
    m_e = cyc + 2;
    model_clear();
    tick(3);
  endtask

  function automatic logic [31:0] exp_word();
    return 32'(m_beats % m_wpt) + m_off;
  endfunction

  task automatic send_data(input logic [511:0] d, input logic [63:0] k);
    logic [511:0] ed;
    bit bad;
    ed = {480'd0, exp_word()};
    bad = 1'b0;
    for (int b = 0; b < 64; b++)
      if (k[b] && d[b*8 +: 8] != ed[b*8 +: 8]) bad = 1'b1;
    if (bad) begin
      m_errors++;
      if (m_errors == 1) m_first = m_beats;
    end
    i_rx_data_valid = 1'b1;
    i_rx_data_data = d;
    i_rx_data_keep = k;
    i_rx_data_last = ((m_beats + 1) % m_wpt) == 0;
    tick();
    i_rx_data_valid = 1'b0;
    m_beats++;
    if (m_beats == m_wpt * m_ops) m_l = cyc;
  endtask

  task automatic rand_beat();
    logic [511:0] d;
    logic [63:0] k;
    int r, b;
    d = {480'd0, exp_word()};
    k = '1;
    r = $urandom_range(0, 3);
    b = $urandom_range(0, 63);
    if (r == 2) k = {$urandom, $urandom};
    if (r != 0) d[b*8 +: 8] = d[b*8 +: 8] ^ 8'($urandom_range(1, 255));
    send_data(d, k);
    tick($urandom_range(0, 2));
  endtask

  task automatic send_notif(input logic [31:0] len, input logic [15:0] sess);
    bit hs;
    hs = 1'b0;
    i_notif_data = {len, sess};
    i_notif_valid = 1'b1;
    for (int t = 0; t < 100 && !hs; t++) begin
      @(negedge clk);
      hs = o_notif_ready;
      tick();
    end
    i_notif_valid = 1'b0;
    chk("notif_accept", 64'(hs), 64'd1);
    m_notifs++;
    if (len != 0) begin
      exp_q.push_back({len, sess});
      acc_cyc = cyc;
    end
  endtask

  task automatic notif_stalled(input logic [31:0] len, input logic [15:0] sess, input int stall);
    i_read_ready = 1'b0;
    send_notif(len, sess);
    tick(stall);
    i_read_ready = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    chk("req_drain", 64'(exp_q.size()), 64'd0);
    i_read_ready = 1'b0;
  endtask

  task automatic check_status(input string tag);
    tick(3);
    chk({tag, "_words"}, 64'(o_status_reg[2]), 64'(m_beats));
    chk({tag, "_errors"}, 64'(o_status_reg[3]), 64'(m_errors));
    chk({tag, "_first"}, 64'(o_status_reg[4]), 64'(m_first));
    chk({tag, "_ops"}, 64'(o_status_reg[5]), 64'(m_beats / m_wpt));
    chk({tag, "_notifs"}, 64'(o_status_reg[1]), 64'(m_notifs));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) chk($sformatf("rst_status%0d", i), 64'(o_status_reg[i]), i == 4 ? 64'hFFFF_FFFF : 64'd0);
    chk("rst_notif_ready", 64'(o_notif_ready), 64'd0);
    chk("rst_read_valid", 64'(o_read_valid), 64'd0);
    chk("rst_read_data", 64'(o_read_data), 64'd0);
    chk("rx_ready", 64'({o_rx_data_ready, o_rx_meta_ready}), 64'd3);

    // directed run: stalled requests, zero-length notification, corrupted beat 17
    cfg(1024, 4, 32'h100);
    do_start();
    for (int i = 0; i < 3; i++) notif_stalled(1024, 16'd5, 10);
    send_notif(0, 16'd5);
    tick(3);
    chk("zero_len_state", 64'(o_status_reg[6]), 64'd1);
    chk("zero_len_notifs", 64'(o_status_reg[1]), 64'd4);
    for (int i = 0; i < 64; i++) begin
      send_data(i == 17 ? 512'd0 : {480'd0, exp_word()}, '1);
      tick($urandom_range(0, 2));
    end
    check_status("dir");
    chk("dir_cycles", 64'(o_status_reg[0]), 64'(m_l - m_e));
    tick(20);
    chk("dir_cycles_frozen", 64'(o_status_reg[0]), 64'(m_l - m_e));

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      cfg(64 * $urandom_range(1, 8), $urandom_range(1, 4), $urandom);
      do_start();
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 2) == 0) send_notif(0, 16'($urandom));
        else notif_stalled(64 * $urandom_range(1, 32), 16'($urandom), $urandom_range(0, 5));
      end
      for (int i = 0; i < int'(m_wpt * m_ops); i++) rand_beat();
      check_status($sformatf("rnd%0d", r));
      chk($sformatf("rnd%0d_cycles", r), 64'(o_status_reg[0]), 64'(m_l - m_e));
    end

    // start edge coincident with a data beat
    cfg(512, 2, 32'd7);
    do_start();
    for (int i = 0; i < 3; i++) rand_beat();
    i_control_reg[7][1] = 1'b0;
    tick(3);
    i_control_reg[7][1] = 1'b1;
    tick();
    i_rx_data_valid = 1'b1;
    i_rx_data_data = 512'hDEAD;
    i_rx_data_keep = '1;
    tick();
    i_rx_data_valid = 1'b0;
    model_clear();
    check_status("coinc");
    for (int i = 0; i < 5; i++) send_data({480'd0, exp_word()}, '1);
    check_status("coinc_after");

    // reset while a request is pending
    i_read_ready = 1'b0;
    send_notif(256, 16'd9);
    @(negedge clk);
    mon_en = 1'b0;
    chk("pre_rst_valid", 64'(o_read_valid), 64'd1);
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("post_rst_valid", 64'(o_read_valid), 64'd0);
    chk("post_rst_words", 64'(o_status_reg[2]), 64'd0);
    chk("post_rst_first", 64'(o_status_reg[4]), 64'hFFFF_FFFF);
    chk("post_rst_state", 64'(o_status_reg[6]), 64'd0);
    chk("post_rst_notif_ready", 64'(o_notif_ready), 64'd0);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
